// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared types and helpers for the serial word link.
//   rx_state_t   : receiver frame state (IDLE / SHIFT / PARITY)
//   count_width  : width of a bit counter that must hold values 0..n
// The PARITY state only becomes reachable when SERIAL_RX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SHIFT  = 2'd1,
    RX_PARITY = 2'd2
  } rx_state_t;

  // A counter that reaches n (one past the last bit index) needs clog2(n+1) bits.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : serial_pkg

// File: rtl/bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// Clear/increment bit counter with a terminal-count compare. Shared between the
// serial receiver and the planned serial transmitter.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset (count -> 0)
//   clear       in   restart the count; combined with inc the count restarts at 1,
//                    so the bit sampled in the restarting cycle is already counted
//   inc         in   count one event
//   terminal    in   [WIDTH] compare value
//   at_terminal out  count == terminal (combinational)
// -----------------------------------------------------------------------------
module bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] terminal,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count;

  // NOTE: state is written with non-blocking (<=) assignments so every flop
  // samples its inputs as they were before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_terminal = (count == terminal);

endmodule : bit_counter

// File: rtl/serial_word_receiver.sv
// -----------------------------------------------------------------------------
// serial_word_receiver
// MSB-first serial-to-parallel receiver. Bits are sampled only on Enable
// strobes; Start (with Enable) marks the MSB of a frame and always restarts
// framing, aborting any partial word. Each completed word goes to a
// single-entry Valid/Ready buffer; a word that completes while the buffer is
// full and not being consumed is dropped and raises the sticky Overrun flag.
//
// Build option: define SERIAL_RX_PARITY_EN to append an even-parity bit to each
// frame. The word is then delivered on the parity sample and mismatches raise
// the sticky ParityErr flag. Without it ParityErr is constant 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   Enable     in   bit strobe; Sin/Start are only looked at when high
//   Start      in   frame marker; this cycle's Sin is bit N-1
//   Sin        in   serial data, MSB first
//   Ready      in   consumer accepts Dout when Valid & Ready
//   ClrErr     in   clears Overrun / ParityErr at the next edge
//   Dout       out  [N] last delivered word (held after consumption)
//   Valid      out  Dout holds an unconsumed word
//   Busy       out  frame in progress
//   Overrun    out  sticky: a completed word was dropped
//   ParityErr  out  sticky: parity mismatch seen
// -----------------------------------------------------------------------------
module serial_word_receiver
  import serial_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Enable,
  input  logic         Start,
  input  logic         Sin,
  input  logic         Ready,
  input  logic         ClrErr,
  output logic [N-1:0] Dout,
  output logic         Valid,
  output logic         Busy,
  output logic         Overrun,
  output logic         ParityErr
);

  localparam int CW = count_width(N);

  rx_state_t    state;
  rx_state_t    state_next;
  logic [N-1:0] shreg;

  logic         shift_en;   // shift Sin into shreg this cycle
  logic         cnt_clear;  // restart the bit count
  logic         cnt_inc;    // count the bit sampled this cycle
  logic         complete;   // a word is finished at this edge
  logic [N-1:0] word;       // the finished word when complete=1
  logic         at_last;    // bit count says this sample is the Nth data bit
`ifdef SERIAL_RX_PARITY_EN
  logic         parity_bad;
`endif

  // Frame position: counts data bits sampled since Start.
  bit_counter #(
    .WIDTH (CW)
  ) u_bit_counter (
    .clk         (clk),
    .reset       (reset),
    .clear       (cnt_clear),
    .inc         (cnt_inc),
    .terminal    (CW'(N - 1)),
    .at_terminal (at_last)
  );

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_next = state;
    shift_en   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    complete   = 1'b0;
    // Without parity the last data bit is still on Sin at the completing edge.
    word       = N'({shreg, Sin});
`ifdef SERIAL_RX_PARITY_EN
    parity_bad = 1'b0;
`endif

    if (Enable) begin
      if (Start) begin
        // Start in any state opens a fresh frame; a partial one is discarded
        // silently.
        shift_en   = 1'b1;
        cnt_clear  = 1'b1;
        cnt_inc    = 1'b1;
        state_next = RX_SHIFT;
      end else begin
        case (state)
          RX_SHIFT: begin
            shift_en = 1'b1;
            cnt_inc  = 1'b1;
            if (at_last) begin
`ifdef SERIAL_RX_PARITY_EN
              // Word is now complete in shreg; wait for its parity bit.
              state_next = RX_PARITY;
`else
              complete   = 1'b1;
              state_next = RX_IDLE;
`endif
            end
          end
`ifdef SERIAL_RX_PARITY_EN
          RX_PARITY: begin
            word       = shreg;
            parity_bad = ^{shreg, Sin};
            complete   = 1'b1;
            state_next = RX_IDLE;
          end
`endif
          default: ;  // IDLE without Start: strobe ignored
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RX_IDLE;
      // NOTE: the shift register is a handful of flops, not a RAM, so it is
      // reset with the rest of the datapath to keep it deterministic.
      shreg <= '0;
    end else begin
      state <= state_next;
      if (shift_en) begin
        shreg <= N'({shreg, Sin});
      end
    end
  end

  assign Busy = (state != RX_IDLE);

  // ---------------------------------------------------------------------------
  // Single-entry output buffer and overrun flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      Dout    <= '0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      if (complete) begin
        // A consumer taking the old word in the same cycle frees the slot.
        if (!Valid || Ready) begin
          Dout  <= word;
          Valid <= 1'b1;
        end
      end else if (Valid && Ready) begin
        Valid <= 1'b0;
      end

      // Setting wins over a simultaneous clear.
      if (complete && Valid && !Ready) begin
        Overrun <= 1'b1;
      end else if (ClrErr) begin
        Overrun <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Parity error flag
  // ---------------------------------------------------------------------------
`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ParityErr <= 1'b0;
    end else if (complete && parity_bad) begin
      // Raised even when the word itself is dropped by the buffer.
      ParityErr <= 1'b1;
    end else if (ClrErr) begin
      ParityErr <= 1'b0;
    end
  end
`else
  assign ParityErr = 1'b0;
`endif

endmodule : serial_word_receiver

// File: tb/tb_serial_word_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_word_receiver
// Self-checking bench for serial_word_receiver (N=8). A behavioural model built
// on a bit queue predicts every output after every clock edge; directed frames
// cover the basic, gapped, overrun, same-cycle accept, abort, reset and (with
// SERIAL_RX_PARITY_EN) parity cases, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_serial_word_receiver;

  localparam int N = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         Enable;
  logic         Start;
  logic         Sin;
  logic         Ready;
  logic         ClrErr;
  logic [N-1:0] Dout;
  logic         Valid;
  logic         Busy;
  logic         Overrun;
  logic         ParityErr;

  int n_tests = 0;
  int n_fail  = 0;

  serial_word_receiver #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .Enable    (Enable),
    .Start     (Start),
    .Sin       (Sin),
    .Ready     (Ready),
    .ClrErr    (ClrErr),
    .Dout      (Dout),
    .Valid     (Valid),
    .Busy      (Busy),
    .Overrun   (Overrun),
    .ParityErr (ParityErr)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: frame is a queue of received bits
  // ---------------------------------------------------------------------------
  bit           q[$];
  bit           in_frame    = 1'b0;
  bit           par_pending = 1'b0;
  logic [N-1:0] held        = '0;
  logic [N-1:0] m_dout      = '0;
  bit           m_valid     = 1'b0;
  bit           m_ovr       = 1'b0;
  bit           m_perr      = 1'b0;

  function automatic logic [N-1:0] pack_queue();
    logic [N-1:0] w = '0;
    foreach (q[i]) w = {w[N-2:0], q[i]};
    return w;
  endfunction

  task automatic model_edge(input bit rst, en, st, s, rdy, clr);
    bit           done    = 1'b0;
    bit           bad     = 1'b0;
    logic [N-1:0] w       = '0;
    if (rst) begin
      q.delete();
      in_frame = 0; par_pending = 0; held = '0;
      m_dout = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
      return;
    end
    if (en) begin
      if (st) begin
        q.delete();
        q.push_back(s);
        in_frame    = 1;
        par_pending = 0;
      end else if (in_frame) begin
        if (par_pending) begin
          w    = held;
          bad  = ((^held) ^ s) != 1'b0;
          done = 1;
          in_frame    = 0;
          par_pending = 0;
        end else begin
          q.push_back(s);
          if (q.size() == N) begin
            if (PAR) begin
              held        = pack_queue();
              par_pending = 1;
            end else begin
              w        = pack_queue();
              done     = 1;
              in_frame = 0;
            end
          end
        end
      end
    end
    // Output buffer and flags use the pre-edge Valid.
    if (done && m_valid && !rdy) m_ovr = 1;
    else if (clr)                m_ovr = 0;
    if (done && bad)             m_perr = 1;
    else if (clr)                m_perr = 0;
    if (done) begin
      if (!m_valid || rdy) begin
        m_dout  = w;
        m_valid = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare all outputs.
  task automatic step(input bit rst, en, st, s, rdy, clr);
    reset  = rst;
    Enable = en;
    Start  = st;
    Sin    = s;
    Ready  = rdy;
    ClrErr = clr;
    @(posedge clk);
    model_edge(rst, en, st, s, rdy, clr);
    #1;
    check("dout",   32'(Dout),      32'(m_dout));
    check("valid",  32'(Valid),     32'(m_valid));
    check("busy",   32'(Busy),      32'(in_frame));
    check("ovr",    32'(Overrun),   32'(m_ovr));
    check("perr",   32'(ParityErr), 32'(m_perr));
  endtask

  task automatic idle(input int cycles, input bit rdy);
    repeat (cycles) step(0, 0, 0, 0, rdy, 0);
  endtask

  // Send one full frame (data bits, then parity bit when enabled).
  // rmode: 0 = Ready low, 1 = Ready high, 2 = Ready only on the completing strobe.
  task automatic send_word(input logic [N-1:0] w, input int gap, input int rmode, input bit flip);
    int total = N + (PAR ? 1 : 0);
    for (int i = 0; i < total; i++) begin
      bit b   = (i < N) ? w[N-1-i] : ((^w) ^ flip);
      bit rdy = (rmode == 1) || (rmode == 2 && i == total - 1);
      step(0, 1, i == 0, b, rdy, 0);
      if (gap > 0 && i < total - 1) idle(gap, rmode == 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1; Enable = 0; Start = 0; Sin = 0; Ready = 0; ClrErr = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 0);
    check("rst_dout",  32'(Dout),      32'h0);
    check("rst_valid", 32'(Valid),     32'h0);
    check("rst_busy",  32'(Busy),      32'h0);
    check("rst_ovr",   32'(Overrun),   32'h0);
    check("rst_perr",  32'(ParityErr), 32'h0);
    idle(2, 0);

    // Basic frame: Valid for exactly one cycle with Ready high.
    send_word(8'hA5, 0, 1, 0);
    check("basic_dout",  32'(Dout),  32'hA5);
    check("basic_valid", 32'(Valid), 32'h1);
    check("basic_busy",  32'(Busy),  32'h0);
    idle(1, 1);
    check("basic_valid_drop", 32'(Valid), 32'h0);

    // Gapped strobes.
    send_word(8'hA5, 3, 1, 0);
    check("gap_dout", 32'(Dout), 32'hA5);
    idle(2, 1);

    // Overrun then clear.
    send_word(8'h3C, 0, 0, 0);
    send_word(8'hC3, 0, 0, 0);
    check("ovr_dout", 32'(Dout),    32'h3C);
    check("ovr_flag", 32'(Overrun), 32'h1);
    step(0, 0, 0, 0, 0, 1);
    check("ovr_clr",  32'(Overrun), 32'h0);
    idle(1, 1);

    // Same-cycle accept on the completing edge.
    send_word(8'h11, 0, 0, 0);
    send_word(8'h22, 0, 2, 0);
    check("acc_dout",  32'(Dout),    32'h22);
    check("acc_valid", 32'(Valid),   32'h1);
    check("acc_ovr",   32'(Overrun), 32'h0);
    idle(1, 1);

    // Abort after 5 bits via a new Start.
    for (int i = 0; i < 5; i++) step(0, 1, i == 0, 1'($urandom), 1, 0);
    send_word(8'hF0, 0, 1, 0);
    check("abort_dout", 32'(Dout),    32'hF0);
    check("abort_ovr",  32'(Overrun), 32'h0);
    idle(1, 1);

    // Reset mid-frame, then a clean frame.
    for (int i = 0; i < 4; i++) step(0, 1, i == 0, 1'($urandom), 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("mrst_dout", 32'(Dout),  32'h0);
    check("mrst_busy", 32'(Busy),  32'h0);
    send_word(8'h0F, 0, 1, 0);
    check("mrst_next", 32'(Dout),  32'h0F);
    idle(1, 1);

`ifdef SERIAL_RX_PARITY_EN
    send_word(8'hA5, 0, 1, 0);
    check("par_ok",   32'(ParityErr), 32'h0);
    send_word(8'hA5, 0, 1, 1);
    check("par_bad",  32'(ParityErr), 32'h1);
    check("par_dout", 32'(Dout),      32'hA5);
    step(0, 0, 0, 0, 1, 1);
    check("par_clr",  32'(ParityErr), 32'h0);
`endif

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      bit en = ($urandom % 3) != 0;
      step(($urandom % 250) == 0, en, en && (($urandom % 12) == 0),
           1'($urandom), 1'($urandom), ($urandom % 20) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_word_receiver
